// File: rtl/pattern_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_uart_pkg
// Description : Shared types and constants for the pattern UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_uart_pkg;

  // Transmitter frame states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 50;

endpackage : pattern_uart_pkg
`default_nettype wire

// File: rtl/pattern_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : pattern_uart_tx_if
// Description : Pattern bus in, UART line and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface pattern_uart_tx_if;
  import pattern_uart_pkg::*;

  logic [DATA_BITS-1:0] pat_in;
  logic                 tx;
  logic                 busy;
  logic                 overrun;

  // Pattern source / UART observer side
  modport master (output pat_in, input tx, input busy, input overrun);
  // Transmitter side
  modport slave  (input pat_in, output tx, output busy, output overrun);

endinterface : pattern_uart_tx_if
`default_nettype wire

// File: rtl/pattern_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick
// Description : Bit-period counter; tick is high on the last cycle of a bit.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick #(
  parameter int CLKS_PER_BIT = 50
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  output logic      tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  assign tick = (baud_cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule : baud_tick
`default_nettype wire

// File: rtl/pattern_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : pattern_uart_tx
// Description : Serialises every change of the LED pattern bus as an 8N1
//               UART frame, with a one-deep pending buffer and sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_uart_tx
  import pattern_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pattern_uart_tx_if.slave   bus
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] pat_q;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_vld;
  logic [BIT_W-1:0]     bit_cnt;

  logic tick;
  logic baud_clear;
  logic change;
  logic frame_end;
  logic consumed;
  logic direct;
  logic capture;

  assign change     = (bus.pat_in != pat_q);
  assign baud_clear = (state == IDLE);
  assign frame_end  = (state == STOP) && tick;
  // Pending entry leaves for the next frame at this edge
  assign consumed   = frame_end && pend_vld;
  // Frame end with nothing pending: a change goes straight to the shifter
  assign direct     = frame_end && !pend_vld;
  assign capture    = (state != IDLE) && change && !direct;

  baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  // Change detect, frame FSM with registered tx/busy, pending buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      shift       <= '0;
      pend_data   <= '0;
      pend_vld    <= 1'b0;
      bit_cnt     <= '0;
      bus.tx      <= 1'b1;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      pat_q <= bus.pat_in;

      case (state)
        IDLE: begin
          bus.tx <= 1'b1;
          if (change) begin
            shift    <= bus.pat_in;
            bit_cnt  <= '0;
            state    <= START;
            bus.tx   <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            bus.tx <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              state  <= STOP;
              bus.tx <= 1'b1;
            end else begin
              // tx follows the bit that becomes shift[0] after this shift
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              bus.tx  <= shift[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            bit_cnt <= '0;
            if (pend_vld) begin
              shift  <= pend_data;
              state  <= START;
              bus.tx <= 1'b0;
            end else if (change) begin
              shift  <= bus.pat_in;
              state  <= START;
              bus.tx <= 1'b0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.tx   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (capture) begin
        pend_data <= bus.pat_in;
        pend_vld  <= 1'b1;
        if (pend_vld && !consumed) begin
          bus.overrun <= 1'b1;
        end
      end else if (consumed) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule : pattern_uart_tx
`default_nettype wire
